// File: rtl/lightboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lightboard_pkg
// Description : Shared constants, RGB565 field positions, the mask FSM state
//               type and the marker-compare helper for the lightboard path.
// Revision    : 1.0 - initial release
// ============================================================================
package lightboard_pkg;

  // Coordinate widths wide enough for 1024x768 rasters
  localparam int X_W     = 11;
  localparam int Y_W     = 10;
  localparam int COUNT_W = 20;

  localparam int DEF_H_ACTIVE = 1024;
  localparam int DEF_V_ACTIVE = 768;

  // RGB565 layout {R[15:11], G[10:5], B[4:0]}
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  typedef enum logic [2:0] {
    WAIT_SOF = 3'd0,
    STREAM   = 3'd1,
    DRAIN    = 3'd2,
    REPORT   = 3'd3,
    ABORT    = 3'd4
  } mask_state_t;

  // Inclusive colour-window test: bright red, little green, little blue
  function automatic logic is_marker(input logic [15:0] pix,
                                     input logic [4:0]  r_min,
                                     input logic [5:0]  g_max,
                                     input logic [4:0]  b_max);
    return (pix[R_MSB:R_LSB] >= r_min) &&
           (pix[G_MSB:G_LSB] <= g_max) &&
           (pix[B_MSB:B_LSB] <= b_max);
  endfunction

endpackage
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : raster_counter
// Description : Column/row tracker for an active-video pixel stream. Reports
//               the coordinates of the pixel presented this cycle, a
//               last-pixel-of-frame flag and whether the counter sits at the
//               frame origin.
// Revision    : 1.0 - initial release
// ============================================================================
module raster_counter
  import lightboard_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           valid_in,
  input  logic           sync_in,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           last_out,
  output logic           at_origin_out
);

  logic [X_W-1:0] col_q, col_d;
  logic [Y_W-1:0] row_q, row_d;

  // Current pixel position (sync forces origin) and next expected position
  always_comb begin
    x_out         = sync_in ? '0 : col_q;
    y_out         = sync_in ? '0 : row_q;
    last_out      = (x_out == X_W'(H_ACTIVE - 1)) && (y_out == Y_W'(V_ACTIVE - 1));
    at_origin_out = (col_q == '0) && (row_q == '0);
    col_d         = col_q;
    row_d         = row_q;
    if (valid_in) begin
      if (x_out == X_W'(H_ACTIVE - 1)) begin
        col_d = '0;
        row_d = (y_out == Y_W'(V_ACTIVE - 1)) ? '0 : y_out + 1'b1;
      end else begin
        col_d = x_out + 1'b1;
        row_d = y_out;
      end
    end
  end

  // Position register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/color_mask_stream.sv
`default_nettype none
// ============================================================================
// Module      : color_mask_stream
// Description : Thresholds an RGB565 pixel stream into an (x, y, valid)
//               marker stream, counts marker pixels per frame and emits a
//               frame-end tabulate / frame-empty pulse or an abort pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module color_mask_stream
  import lightboard_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int MIN_PIXELS = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [15:0]        pixel_in,
  input  logic               pixel_valid_in,
  input  logic               frame_start_in,
  input  logic [4:0]         r_min_in,
  input  logic [5:0]         g_max_in,
  input  logic [4:0]         b_max_in,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic               valid_out,
  output logic               tabulate_out,
  output logic               frame_empty_out,
  output logic               frame_err_out,
  output logic [COUNT_W-1:0] pixel_count_out
);

  mask_state_t state_q, state_d;
  logic        pending_q, pending_d;

  logic [X_W-1:0] cur_x;
  logic [Y_W-1:0] cur_y;
  logic           cur_last;
  logic           at_origin;
  logic           sof;
  logic           live;

  // Stage 1: accepted pixel, its position and the thresholds in force
  logic           s1_valid_q, s1_valid_d;
  logic           s1_sof_q, s1_sof_d;
  logic [15:0]    s1_pix_q, s1_pix_d;
  logic [X_W-1:0] s1_x_q, s1_x_d;
  logic [Y_W-1:0] s1_y_q, s1_y_d;
  logic [4:0]     s1_rmin_q, s1_rmin_d;
  logic [5:0]     s1_gmax_q, s1_gmax_d;
  logic [4:0]     s1_bmax_q, s1_bmax_d;

  // Stage 2: compare result, emitted coordinates and the running count
  logic               marker;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic               valid_q, valid_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // Frame-level pulses and the reported count
  logic               tab_q, tab_d;
  logic               empty_q, empty_d;
  logic               err_q, err_d;
  logic [COUNT_W-1:0] pcount_q, pcount_d;

  assign sof = pixel_valid_in & frame_start_in;

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_raster (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .valid_in      (pixel_valid_in),
    .sync_in       (sof),
    .x_out         (cur_x),
    .y_out         (cur_y),
    .last_out      (cur_last),
    .at_origin_out (at_origin)
  );

  // A pixel belongs to a frame once a sync has been seen; pixels between a
  // frame's last pixel and the next sync are dropped
  always_comb begin
    live = pixel_valid_in &
           (frame_start_in || pending_q || (state_q == STREAM) || (state_q == ABORT));
  end

  // Stage 1 capture
  always_comb begin
    s1_valid_d = live;
    s1_sof_d   = sof;
    s1_pix_d   = pixel_valid_in ? pixel_in : s1_pix_q;
    s1_x_d     = pixel_valid_in ? cur_x    : s1_x_q;
    s1_y_d     = pixel_valid_in ? cur_y    : s1_y_q;
    s1_rmin_d  = r_min_in;
    s1_gmax_d  = g_max_in;
    s1_bmax_d  = b_max_in;
  end

  // Stage 2 compare; a frame's first pixel restarts the count here so the
  // previous frame's total stays readable while its report is pending
  always_comb begin
    marker  = s1_valid_q && is_marker(s1_pix_q, s1_rmin_q, s1_gmax_q, s1_bmax_q);
    valid_d = marker;
    x_d     = s1_valid_q ? s1_x_q : x_q;
    y_d     = s1_valid_q ? s1_y_q : y_q;
    count_d = count_q;
    if (s1_sof_q) begin
      count_d = marker ? COUNT_W'(1) : '0;
    end else if (marker && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Frame FSM: next state, pending sync and frame-level pulses
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    tab_d     = 1'b0;
    empty_d   = 1'b0;
    err_d     = 1'b0;
    pcount_d  = pcount_q;
    unique case (state_q)
      WAIT_SOF: begin
        if (sof) state_d = cur_last ? DRAIN : STREAM;
      end
      STREAM, ABORT: begin
        if (state_q == ABORT) state_d = STREAM;
        if (sof && !at_origin) begin
          err_d   = 1'b1;
          state_d = cur_last ? DRAIN : ABORT;
        end else if (pixel_valid_in && cur_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (sof) pending_d = 1'b1;
        state_d = REPORT;
      end
      REPORT: begin
        pcount_d  = count_q;
        tab_d     = (count_q >= COUNT_W'(MIN_PIXELS));
        empty_d   = (count_q <  COUNT_W'(MIN_PIXELS));
        pending_d = 1'b0;
        state_d   = (pending_q || sof) ? STREAM : WAIT_SOF;
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  // All state registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= WAIT_SOF;
      pending_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_pix_q   <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_rmin_q  <= '0;
      s1_gmax_q  <= '0;
      s1_bmax_q  <= '0;
      x_q        <= '0;
      y_q        <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      tab_q      <= 1'b0;
      empty_q    <= 1'b0;
      err_q      <= 1'b0;
      pcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      s1_valid_q <= s1_valid_d;
      s1_sof_q   <= s1_sof_d;
      s1_pix_q   <= s1_pix_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_rmin_q  <= s1_rmin_d;
      s1_gmax_q  <= s1_gmax_d;
      s1_bmax_q  <= s1_bmax_d;
      x_q        <= x_d;
      y_q        <= y_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      tab_q      <= tab_d;
      empty_q    <= empty_d;
      err_q      <= err_d;
      pcount_q   <= pcount_d;
    end
  end

  assign x_out           = x_q;
  assign y_out           = y_q;
  assign valid_out       = valid_q;
  assign tabulate_out    = tab_q;
  assign frame_empty_out = empty_q;
  assign frame_err_out   = err_q;
  assign pixel_count_out = pcount_q;

endmodule
`default_nettype wire

// File: tb/tb_color_mask_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_color_mask_stream
// Description : Directed bench for color_mask_stream on a 16x12 raster.
//               dut_a uses MIN_PIXELS=16, dut_b uses MIN_PIXELS=1; both see
//               the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_color_mask_stream;

  localparam int H = 16;
  localparam int V = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pixel = '0;
  logic        pv = 1'b0;
  logic        fs = 1'b0;
  logic [4:0]  r_min = 5'd16;
  logic [5:0]  g_max = 6'd8;
  logic [4:0]  b_max = 5'd8;

  logic [10:0] a_x, b_x;
  logic [9:0]  a_y, b_y;
  logic        a_valid, b_valid, a_tab, b_tab, a_empty, b_empty, a_err, b_err;
  logic [19:0] a_cnt, b_cnt;

  color_mask_stream #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(16)) dut_a (
    .clk_in(clk), .rst_in(rst), .pixel_in(pixel), .pixel_valid_in(pv),
    .frame_start_in(fs), .r_min_in(r_min), .g_max_in(g_max), .b_max_in(b_max),
    .x_out(a_x), .y_out(a_y), .valid_out(a_valid), .tabulate_out(a_tab),
    .frame_empty_out(a_empty), .frame_err_out(a_err), .pixel_count_out(a_cnt));

  color_mask_stream #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(1)) dut_b (
    .clk_in(clk), .rst_in(rst), .pixel_in(pixel), .pixel_valid_in(pv),
    .frame_start_in(fs), .r_min_in(r_min), .g_max_in(g_max), .b_max_in(b_max),
    .x_out(b_x), .y_out(b_y), .valid_out(b_valid), .tabulate_out(b_tab),
    .frame_empty_out(b_empty), .frame_err_out(b_err), .pixel_count_out(b_cnt));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Event monitor, sampled on the falling edge
  int a_hits = 0, a_win = 0, a_tabs = 0, a_empties = 0, a_errs = 0;
  int a_lx = 0, a_ly = 0, a_tab_cyc = 0, a_err_cyc = 0, a_rep_prev = 0, a_rep_last = 0;
  int b_hits = 0, b_tabs = 0, b_empties = 0, b_errs = 0;
  int b_lx = 0, b_ly = 0, b_vcyc = 0, b_tab_cyc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_valid) begin
        a_hits++;
        if (a_x >= 4 && a_x <= 7 && a_y >= 2 && a_y <= 5) a_win++;
        a_lx = int'(a_x);
        a_ly = int'(a_y);
      end
      if (a_tab || a_empty) begin
        a_rep_prev = a_rep_last;
        a_rep_last = int'(a_cnt);
      end
      if (a_tab)   begin a_tabs++; a_tab_cyc = cyc; end
      if (a_empty) a_empties++;
      if (a_err)   begin a_errs++; a_err_cyc = cyc; end
      if (b_valid) begin
        b_hits++;
        b_lx   = int'(b_x);
        b_ly   = int'(b_y);
        b_vcyc = cyc;
      end
      if (b_tab)   begin b_tabs++; b_tab_cyc = cyc; end
      if (b_empty) b_empties++;
      if (b_err)   b_errs++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pix_for(input int mode, input int x, input int y);
    logic m;
    m = 1'b0;
    case (mode)
      0: m = (x >= 4 && x <= 7 && y >= 2 && y <= 5);
      1: m = (x >= 4 && x <= 7 && y >= 2 && y <= 5) && !(x == 7 && y == 5);
      2: m = (x == 15 && y == 11);
      3: m = (y == 0) || (y == 1 && x < 4);
      4: m = (y < 2) || (y == 2 && x < 8);
      6: begin
        if (y == 0) begin
          case (x)
            0: return 16'h8108;  // R=16 G=8 B=8 : exactly on every limit
            1: return 16'h7908;  // R=15          : red one short
            2: return 16'h8128;  // G=9           : green one over
            3: return 16'h8109;  // B=9           : blue one over
            default: return 16'h0000;
          endcase
        end
      end
      default: m = 1'b0;
    endcase
    return m ? 16'hF800 : 16'h0000;
  endfunction

  int last_acc = 0;
  int fs_acc   = 0;

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic px(input logic [15:0] p, input logic f);
    pixel    = p;
    pv       = 1'b1;
    fs       = f;
    last_acc = cyc;
    @(posedge clk); #1;
    pv = 1'b0;
    fs = 1'b0;
  endtask

  task automatic send_frame(input int mode, input bit gaps);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        if (x == 0 && y == 0) fs_acc = cyc;
        px(pix_for(mode, x, y), (x == 0 && y == 0));
      end
    end
  endtask

  task automatic send_partial(input int mode, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 0) fs_acc = cyc;
      px(pix_for(mode, i % H, i / H), (i == 0));
    end
  endtask

  int h0, w0, t0, e0, r0, bh0, bt0, be0;

  task automatic snap();
    h0 = a_hits; w0 = a_win; t0 = a_tabs; e0 = a_empties; r0 = a_errs;
    bh0 = b_hits; bt0 = b_tabs; be0 = b_errs;
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #20;
    check("rst_x",     int'(a_x), 0);
    check("rst_valid", int'(a_valid), 0);
    check("rst_pulses", int'({a_tab, a_empty, a_err}), 0);
    check("rst_count", int'(a_cnt), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(3);

    // Pixels before any sync never produce valid_out
    snap();
    for (int i = 0; i < 8; i++) px(16'hF800, 1'b0);
    idle(4);
    check("presync_hits", a_hits - h0, 0);

    // 1: 4x4 marker block, exactly MIN_PIXELS hits
    snap();
    send_frame(0, 1'b0);
    idle(6);
    check("t1_hits",    a_hits - h0, 16);
    check("t1_in_win",  a_win - w0, 16);
    check("t1_tabs",    a_tabs - t0, 1);
    check("t1_empties", a_empties - e0, 0);
    check("t1_count",   int'(a_cnt), 16);
    check("t1_tab_lat", a_tab_cyc - last_acc, 3);

    // 2: one short of MIN_PIXELS
    snap();
    send_frame(1, 1'b0);
    idle(6);
    check("t2_hits",    a_hits - h0, 15);
    check("t2_empties", a_empties - e0, 1);
    check("t2_tabs",    a_tabs - t0, 0);
    check("t2_count",   int'(a_cnt), 15);

    // 3: single marker at the last pixel with random gaps
    snap();
    send_frame(2, 1'b1);
    idle(6);
    check("t3_b_hits",  b_hits - bh0, 1);
    check("t3_b_x",     b_lx, H - 1);
    check("t3_b_y",     b_ly, V - 1);
    check("t3_b_vlat",  b_vcyc - last_acc, 2);
    check("t3_b_tablat", b_tab_cyc - b_vcyc, 1);
    check("t3_b_tabs",  b_tabs - bt0, 1);
    check("t3_b_count", int'(b_cnt), 1);
    check("t3_a_empty", a_empties - e0, 1);

    // Inclusive threshold edges: only the on-limit pixel is a marker
    snap();
    send_frame(6, 1'b0);
    idle(6);
    check("thr_hits",  a_hits - h0, 1);
    check("thr_x",     a_lx, 0);
    check("thr_count", int'(a_cnt), 1);
    check("thr_b_tab", b_tabs - bt0, 1);

    // 4: early frame start at (9,6), then a complete frame
    snap();
    send_partial(0, 6 * H + 9);
    send_frame(0, 1'b0);
    idle(6);
    check("t4_errs",    a_errs - r0, 1);
    check("t4_b_errs",  b_errs - be0, 1);
    check("t4_err_lat", a_err_cyc - fs_acc, 1);
    check("t4_tabs",    a_tabs - t0, 1);
    check("t4_empties", a_empties - e0, 0);
    check("t4_count",   int'(a_cnt), 16);

    // 6: back-to-back frames, 20 then 40 markers
    snap();
    send_frame(3, 1'b0);
    send_frame(4, 1'b0);
    idle(6);
    check("t6_tabs",  a_tabs - t0, 2);
    check("t6_first", a_rep_prev, 20);
    check("t6_second", a_rep_last, 40);

    // 5: asynchronous reset mid-frame
    send_partial(0, 40);
    #2 rst = 1'b1;
    #1;
    check("t5_valid",  int'(a_valid), 0);
    check("t5_x",      int'(a_x), 0);
    check("t5_y",      int'(a_y), 0);
    check("t5_count",  int'(a_cnt), 0);
    check("t5_pulses", int'({a_tab, a_empty, a_err}), 0);
    @(posedge clk); #1 rst = 1'b0;
    snap();
    for (int i = 0; i < 40; i++) px(16'hF800, 1'b0);
    idle(6);
    check("t5_nosync_hits", a_hits - h0, 0);
    check("t5_nosync_rep",  (a_tabs - t0) + (a_empties - e0), 0);
    send_frame(0, 1'b0);
    idle(6);
    check("t5_recover_tab", a_tabs - t0, 1);
    check("t5_recover_cnt", int'(a_cnt), 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/color_mask_stream.md
# color_mask_stream

Converts the camera's RGB565 pixel stream into the thresholded `(x, y, valid)` stream consumed by `center_of_mass`. Generates the frame-end `tabulate` strobe for that block. Sits between the camera capture/crossing stage and `center_of_mass`. Tracks raster position internally, counts marker pixels per frame, and suppresses tabulation of frames with too few hits.

## Interface
- `H_ACTIVE`, default 1024: active pixels per line.
- `V_ACTIVE`, default 768: active lines per frame.
- `MIN_PIXELS`, default 16: minimum marker pixels for a frame to be tabulated.
- `clk_in` input, 1 bit: system clock, single domain.
- `rst_in` input, 1 bit: asynchronous, active-high reset.
- `pixel_in` input, 16 bits: RGB565 as {R[15:11], G[10:5], B[4:0]}.
- `pixel_valid_in` input, 1 bit: `pixel_in` carries an active pixel this cycle.
- `frame_start_in` input, 1 bit: qualified by `pixel_valid_in`; marks pixel (0,0).
- `r_min_in` input, 5 bits: marker requires R ≥ r_min_in.
- `g_max_in` input, 6 bits: marker requires G ≤ g_max_in.
- `b_max_in` input, 5 bits: marker requires B ≤ b_max_in.
- `x_out` output, 11 bits: column of the emitted pixel.
- `y_out` output, 10 bits: row of the emitted pixel.
- `valid_out` output, 1 bit: emitted pixel is a marker pixel.
- `tabulate_out` output, 1 bit: one-cycle pulse at frame end when count ≥ MIN_PIXELS.
- `frame_empty_out` output, 1 bit: one-cycle pulse at frame end when count < MIN_PIXELS.
- `frame_err_out` output, 1 bit: one-cycle pulse when a frame is aborted by an early `frame_start_in`.
- `pixel_count_out` output, 20 bits: marker count of the last completed frame.

## Operation
- **Coordinate counters.** `col` and `row` advance only on `pixel_valid_in`.
  - `frame_start_in & pixel_valid_in` forces that pixel to (0,0). Counters then go to (1,0).
  - `col` wraps at H_ACTIVE-1 to 0 and increments `row`.
  - The pixel at (H_ACTIVE-1, V_ACTIVE-1) is the last pixel of the frame.
- **Threshold.** A pixel is a marker pixel when all three compares hold; compares are inclusive. Threshold inputs are sampled in pipeline stage 1.
- **Per-pixel outputs.** `x_out`/`y_out` present the coordinates of every accepted pixel. `valid_out` is 1 only for marker pixels.
  - When no pixel is in flight, `valid_out` = 0 and `x_out`/`y_out` hold their last values.
- **Marker counter.** 20 bits; saturates at 2^20-1 (a full 1024×768 frame fits). Clears on `frame_start_in`.
- **FSM states:**
  - WAIT_SOF: discard pixels until `frame_start_in`; then go to STREAM.
  - STREAM: last pixel accepted → DRAIN; `frame_start_in` on any pixel other than (0,0) → ABORT.
  - DRAIN: wait for the pipeline to empty → REPORT.
  - REPORT: latch `pixel_count_out`; pulse `tabulate_out` or `frame_empty_out`; → WAIT_SOF.
  - ABORT: pulse `frame_err_out`; drop the partial count; treat the triggering pixel as (0,0) of a new frame; → STREAM.
- **Frame-start handling.** A `frame_start_in` arriving in DRAIN or REPORT is held in a pending flag. Its pixel still enters the pipeline as (0,0) of the next frame; the previous frame's report is not lost.
- **Pixels before first sync.** Pixels arriving in WAIT_SOF never assert `valid_out`.
- **Reset values.** All outputs, counters and the pending flag are 0. State is WAIT_SOF. Reset mid-frame discards everything; no report pulses.

## Timing
- **Latency:** 2 cycles from `pixel_valid_in` to the corresponding `x_out`/`y_out`/`valid_out` (stage 1 register, stage 2 compare+register).
- **Throughput:** full rate, one pixel per cycle; no backpressure. Gaps in `pixel_valid_in` are allowed anywhere.
- **Frame-end pulse:** `tabulate_out`/`frame_empty_out` rise exactly 1 cycle after the last pixel's `valid_out` slot, i.e. 3 cycles after it is accepted. Pulse width is 1 cycle.
- **Count timing:** `pixel_count_out` updates in the same cycle as the frame-end pulse and is stable until the next report.
- **Error timing:** `frame_err_out` asserts 1 cycle after the offending `frame_start_in` is accepted.
- **Priority:** `rst_in` > REPORT pulse > ABORT.

## Structure
- **Shared package `lightboard_pkg`:**
  - coordinate width constants (11/10);
  - RGB565 field bit positions;
  - FSM state enum `mask_state_t`;
  - default H_ACTIVE/V_ACTIVE.
- **Sub-module `raster_counter`:** col/row counters with sync, wrap and last-pixel flag; reused by the display path.
- **Remainder:** threshold pipeline, marker counter and FSM live in this module.

## Test plan
1. **Threshold frame.** 1024×768 frame, pixels (100..103, 50..53) = 0xF800, others 0x0000; thresholds r_min=16, g_max=8, b_max=8.
   - 16 `valid_out` pulses at those coordinates.
   - `tabulate_out` 3 cycles after the last pixel.
   - `pixel_count_out` = 16.
2. **Below minimum.** Same frame with only 15 marker pixels → `frame_empty_out` pulse, no `tabulate_out`, `pixel_count_out` = 15.
3. **Boundary and gaps.** Single marker at (1023, 767) with random `pixel_valid_in` gaps; MIN_PIXELS=1.
   - `x_out`=1023, `y_out`=767, `valid_out` = 1.
   - `tabulate_out` follows on the next cycle.
4. **Early frame start.** `frame_start_in` at pixel (500, 300) of a frame.
   - `frame_err_out` pulses.
   - No tabulate for the aborted frame.
   - The next complete frame reports correctly.
5. **Reset mid-frame.** Async `rst_in` mid-frame.
   - All outputs 0 immediately.
   - Pixels until the next `frame_start_in` produce no `valid_out`.
6. **Back-to-back frames.** `frame_start_in` on the cycle right after the last pixel → both reports are emitted and counts do not mix (e.g. 20 then 40).
